// File: rtl/axi_master_burst_if.sv
// AXI4 master bridging a request/stream user port onto AW/W/B/AR/R channels.
// Requests are legality-checked locally; illegal ones are answered with a reject response.
module axi_master_burst_if #(
  parameter int          AXI_ADDR_WIDTH  = 32,
  parameter int          AXI_DATA_WIDTH  = 32,
  parameter int          AXI_ID_WIDTH    = 4,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          IN_ORDER        = 0,
  parameter logic [3:0]  AXI_CACHE       = 4'b0011,
  parameter logic [2:0]  AXI_PROT        = 3'b000,
  localparam int         AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                       axi_clk_in,
  input  logic                       axi_rst_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [AXI_ADDR_WIDTH-1:0]  req_addr_in,
  input  logic [7:0]                 req_len_in,
  input  logic [2:0]                 req_size_in,
  input  logic [1:0]                 req_burst_in,
  input  logic                       wdat_valid_in,
  output logic                       wdat_ready_out,
  input  logic [AXI_DATA_WIDTH-1:0]  wdat_data_in,
  input  logic [AXI_WSTRB_WIDTH-1:0] wdat_strb_in,
  output logic                       rdat_valid_out,
  input  logic                       rdat_ready_in,
  output logic [AXI_DATA_WIDTH-1:0]  rdat_data_out,
  output logic                       rdat_last_out,
  output logic [1:0]                 rdat_resp_out,
  output logic                       resp_valid_out,
  input  logic                       resp_ready_in,
  output logic                       resp_write_out,
  output logic [1:0]                 resp_code_out,
  output logic                       resp_reject_out,
  output logic [AXI_ADDR_WIDTH-1:0]  axi_awaddr_out,
  output logic [7:0]                 axi_awlen_out,
  output logic [2:0]                 axi_awsize_out,
  output logic [1:0]                 axi_awburst_out,
  output logic [AXI_ID_WIDTH-1:0]    axi_awid_out,
  output logic [3:0]                 axi_awcache_out,
  output logic [2:0]                 axi_awprot_out,
  output logic                       axi_awvalid_out,
  input  logic                       axi_awready_in,
  output logic [AXI_DATA_WIDTH-1:0]  axi_wdata_out,
  output logic [AXI_WSTRB_WIDTH-1:0] axi_wstrb_out,
  output logic                       axi_wlast_out,
  output logic                       axi_wvalid_out,
  input  logic                       axi_wready_in,
  input  logic [AXI_ID_WIDTH-1:0]    axi_bid_in,
  input  logic [1:0]                 axi_bresp_in,
  input  logic                       axi_bvalid_in,
  output logic                       axi_bready_out,
  output logic [AXI_ADDR_WIDTH-1:0]  axi_araddr_out,
  output logic [7:0]                 axi_arlen_out,
  output logic [2:0]                 axi_arsize_out,
  output logic [1:0]                 axi_arburst_out,
  output logic [AXI_ID_WIDTH-1:0]    axi_arid_out,
  output logic [3:0]                 axi_arcache_out,
  output logic [2:0]                 axi_arprot_out,
  output logic                       axi_arvalid_out,
  input  logic                       axi_arready_in,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_rdata_in,
  input  logic [AXI_ID_WIDTH-1:0]    axi_rid_in,
  input  logic [1:0]                 axi_rresp_in,
  input  logic                       axi_rlast_in,
  input  logic                       axi_rvalid_in,
  output logic                       axi_rready_out
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {A_IDLE, A_SEND} addr_state_t;
  addr_state_t aw_state, ar_state;

  logic [CW-1:0]           wr_cnt, rd_cnt, wq_cnt;
  logic [7:0]              wq_mem [MAX_OUTSTANDING];
  logic [QW-1:0]           wq_rd, wq_wr;
  logic [7:0]              w_beat;
  logic [AXI_ID_WIDTH-1:0] aw_id_ctr, ar_id_ctr;

  // IDs are not used for routing; completions are counted per direction.
  logic unused_ids;
  assign unused_ids = ^{axi_bid_in, axi_rid_in};

  // Legality
  logic [15:0] burst_bytes, end_off;
  logic        size_ok, aligned, wrap_len_ok, legal;
  assign burst_bytes = (16'(req_len_in) + 16'd1) << req_size_in;
  assign end_off     = 16'(req_addr_in[11:0]) + burst_bytes;
  assign size_ok     = (32'd8 << req_size_in) <= 32'(AXI_DATA_WIDTH);
  assign aligned     = (req_addr_in & ~({AXI_ADDR_WIDTH{1'b1}} << req_size_in)) == '0;
  assign wrap_len_ok = (req_len_in == 8'd1) || (req_len_in == 8'd3) ||
                       (req_len_in == 8'd7) || (req_len_in == 8'd15);
  assign legal = size_ok && (req_burst_in != 2'd3) &&
                 !((req_burst_in == 2'd2) && (!wrap_len_ok || !aligned)) &&
                 !((req_burst_in == 2'd1) && (end_off > 16'd4096));

  logic dir_ok;
  always_comb begin
    dir_ok = 1'b0;
    if (req_write_in)
      dir_ok = (wr_cnt < CW'(MAX_OUTSTANDING)) && (aw_state == A_IDLE) &&
               (wq_cnt < CW'(MAX_OUTSTANDING));
    else
      dir_ok = (rd_cnt < CW'(MAX_OUTSTANDING)) && (ar_state == A_IDLE);
  end

  assign req_ready_out = !axi_rst_in &&
                         (legal ? dir_ok : (!resp_valid_out && !axi_bvalid_in));

  logic accept, reject, aw_acc, ar_acc, b_fire, r_done, w_load, w_fire, w_pop;
  assign accept = req_valid_in && req_ready_out && legal;
  assign reject = req_valid_in && req_ready_out && !legal;
  assign aw_acc = accept && req_write_in;
  assign ar_acc = accept && !req_write_in;

  assign axi_bready_out = !axi_rst_in && (!resp_valid_out || resp_ready_in);
  assign b_fire = axi_bvalid_in && axi_bready_out;

  assign rdat_valid_out = !axi_rst_in && axi_rvalid_in;
  assign rdat_data_out  = axi_rdata_in;
  assign rdat_last_out  = axi_rlast_in;
  assign rdat_resp_out  = axi_rresp_in;
  assign axi_rready_out = !axi_rst_in && rdat_ready_in;
  assign r_done = axi_rvalid_in && axi_rready_out && axi_rlast_in;

  assign w_load         = (wq_cnt != '0) && (!axi_wvalid_out || axi_wready_in);
  assign wdat_ready_out = !axi_rst_in && w_load;
  assign w_fire         = wdat_valid_in && wdat_ready_out;
  assign w_pop          = w_fire && (w_beat == wq_mem[wq_rd]);

  assign axi_awcache_out = AXI_CACHE;
  assign axi_awprot_out  = AXI_PROT;
  assign axi_arcache_out = AXI_CACHE;
  assign axi_arprot_out  = AXI_PROT;

  always_ff @(posedge axi_clk_in) begin
    if (axi_rst_in) begin
      aw_state <= A_IDLE; axi_awvalid_out <= 1'b0; aw_id_ctr <= '0;
      axi_awaddr_out <= '0; axi_awlen_out <= '0; axi_awsize_out <= '0;
      axi_awburst_out <= '0; axi_awid_out <= '0;
    end else begin
      case (aw_state)
        A_IDLE: if (aw_acc) begin
          aw_state        <= A_SEND;
          axi_awvalid_out <= 1'b1;
          axi_awaddr_out  <= req_addr_in;
          axi_awlen_out   <= req_len_in;
          axi_awsize_out  <= req_size_in;
          axi_awburst_out <= req_burst_in;
          axi_awid_out    <= (IN_ORDER != 0) ? '0 : aw_id_ctr;
          aw_id_ctr       <= aw_id_ctr + 1'b1;
        end
        A_SEND: if (axi_awready_in) begin
          aw_state        <= A_IDLE;
          axi_awvalid_out <= 1'b0;
        end
        default: aw_state <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_clk_in) begin
    if (axi_rst_in) begin
      ar_state <= A_IDLE; axi_arvalid_out <= 1'b0; ar_id_ctr <= '0;
      axi_araddr_out <= '0; axi_arlen_out <= '0; axi_arsize_out <= '0;
      axi_arburst_out <= '0; axi_arid_out <= '0;
    end else begin
      case (ar_state)
        A_IDLE: if (ar_acc) begin
          ar_state        <= A_SEND;
          axi_arvalid_out <= 1'b1;
          axi_araddr_out  <= req_addr_in;
          axi_arlen_out   <= req_len_in;
          axi_arsize_out  <= req_size_in;
          axi_arburst_out <= req_burst_in;
          axi_arid_out    <= (IN_ORDER != 0) ? '0 : ar_id_ctr;
          ar_id_ctr       <= ar_id_ctr + 1'b1;
        end
        A_SEND: if (axi_arready_in) begin
          ar_state        <= A_IDLE;
          axi_arvalid_out <= 1'b0;
        end
        default: ar_state <= A_IDLE;
      endcase
    end
  end

  // Outstanding counters and beat-count queue
  always_ff @(posedge axi_clk_in) begin
    if (axi_rst_in) begin
      wr_cnt <= '0; rd_cnt <= '0; wq_cnt <= '0; wq_rd <= '0; wq_wr <= '0;
    end else begin
      if (aw_acc && !b_fire) wr_cnt <= wr_cnt + 1'b1;
      else if (!aw_acc && b_fire) wr_cnt <= wr_cnt - 1'b1;
      if (ar_acc && !r_done) rd_cnt <= rd_cnt + 1'b1;
      else if (!ar_acc && r_done) rd_cnt <= rd_cnt - 1'b1;
      if (aw_acc) begin
        wq_mem[wq_wr] <= req_len_in;
        wq_wr <= (wq_wr == QW'(MAX_OUTSTANDING - 1)) ? '0 : wq_wr + 1'b1;
      end
      if (w_pop)
        wq_rd <= (wq_rd == QW'(MAX_OUTSTANDING - 1)) ? '0 : wq_rd + 1'b1;
      if (aw_acc && !w_pop) wq_cnt <= wq_cnt + 1'b1;
      else if (!aw_acc && w_pop) wq_cnt <= wq_cnt - 1'b1;
    end
  end

  always_ff @(posedge axi_clk_in) begin
    if (axi_rst_in) begin
      axi_wvalid_out <= 1'b0; axi_wlast_out <= 1'b0; w_beat <= '0;
      axi_wdata_out <= '0; axi_wstrb_out <= '0;
    end else if (w_fire) begin
      axi_wvalid_out <= 1'b1;
      axi_wdata_out  <= wdat_data_in;
      axi_wstrb_out  <= wdat_strb_in;
      axi_wlast_out  <= w_pop;
      w_beat         <= w_pop ? '0 : w_beat + 1'b1;
    end else if (axi_wready_in) begin
      axi_wvalid_out <= 1'b0;
    end
  end

  // A B completion always wins; reject is only accepted when no B is pending.
  always_ff @(posedge axi_clk_in) begin
    if (axi_rst_in) begin
      resp_valid_out <= 1'b0; resp_write_out <= 1'b0;
      resp_code_out <= '0; resp_reject_out <= 1'b0;
    end else begin
      if (resp_valid_out && resp_ready_in) resp_valid_out <= 1'b0;
      if (b_fire) begin
        resp_valid_out <= 1'b1; resp_write_out <= 1'b1;
        resp_code_out <= axi_bresp_in; resp_reject_out <= 1'b0;
      end else if (reject) begin
        resp_valid_out <= 1'b1; resp_write_out <= req_write_in;
        resp_code_out <= 2'b10; resp_reject_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_burst_if.sv
// Directed bench for axi_master_burst_if on a 64-bit bus with two outstanding bursts per direction.
module tb_axi_master_burst_if;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, req_write = 0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [1:0]  req_burst = '0;
  logic        wdat_valid = 0;
  logic [63:0] wdat_data = '0;
  logic [7:0]  wdat_strb = '1;
  logic        rdat_ready = 1, resp_ready = 0;
  logic        awready = 0, wready = 1, bvalid = 0, arready = 0;
  logic [3:0]  bid = '0, rid = '0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [63:0] rdata = '0;
  logic        rlast = 0, rvalid = 0;

  logic        req_ready, wdat_ready, rdat_valid, rdat_last, resp_valid, resp_write, resp_reject;
  logic [63:0] rdat_data, wdata;
  logic [1:0]  rdat_resp, resp_code, awburst, arburst;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [3:0]  awid, arid, awcache, arcache;
  logic        awvalid, wlast, wvalid, bready, arvalid, rready;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  axi_master_burst_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
                        .MAX_OUTSTANDING(2), .IN_ORDER(0)) dut (
    .axi_clk_in(clk), .axi_rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_write_in(req_write),
    .req_addr_in(req_addr), .req_len_in(req_len), .req_size_in(req_size), .req_burst_in(req_burst),
    .wdat_valid_in(wdat_valid), .wdat_ready_out(wdat_ready), .wdat_data_in(wdat_data),
    .wdat_strb_in(wdat_strb),
    .rdat_valid_out(rdat_valid), .rdat_ready_in(rdat_ready), .rdat_data_out(rdat_data),
    .rdat_last_out(rdat_last), .rdat_resp_out(rdat_resp),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready), .resp_write_out(resp_write),
    .resp_code_out(resp_code), .resp_reject_out(resp_reject),
    .axi_awaddr_out(awaddr), .axi_awlen_out(awlen), .axi_awsize_out(awsize),
    .axi_awburst_out(awburst), .axi_awid_out(awid), .axi_awcache_out(awcache),
    .axi_awprot_out(awprot), .axi_awvalid_out(awvalid), .axi_awready_in(awready),
    .axi_wdata_out(wdata), .axi_wstrb_out(wstrb), .axi_wlast_out(wlast),
    .axi_wvalid_out(wvalid), .axi_wready_in(wready),
    .axi_bid_in(bid), .axi_bresp_in(bresp), .axi_bvalid_in(bvalid), .axi_bready_out(bready),
    .axi_araddr_out(araddr), .axi_arlen_out(arlen), .axi_arsize_out(arsize),
    .axi_arburst_out(arburst), .axi_arid_out(arid), .axi_arcache_out(arcache),
    .axi_arprot_out(arprot), .axi_arvalid_out(arvalid), .axi_arready_in(arready),
    .axi_rdata_in(rdata), .axi_rid_in(rid), .axi_rresp_in(rresp), .axi_rlast_in(rlast),
    .axi_rvalid_in(rvalid), .axi_rready_out(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic wr, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    req_valid = 1; req_write = wr; req_addr = a; req_len = l; req_size = s; req_burst = b;
    #1;
  endtask

  task automatic send_wbeats(input int n);
    for (int i = 0; i < n; i++) begin
      wdat_valid = 1; wdat_data = 64'(i); tick();
    end
    wdat_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wdat_ready", wdat_ready, 0);
    rst = 0; tick();

    // Write INCR 0x100 len 3 size 2; AW held off while all W beats go out
    set_req(1, 32'h100, 8'd3, 3'd2, 2'd1);
    chk("wr1_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("wr1_awvalid", awvalid, 1);
    chk("wr1_awaddr", awaddr, 32'h100);
    chk("wr1_awlen", awlen, 3);
    chk("wr1_awsize", awsize, 2);
    chk("wr1_awburst", awburst, 1);
    chk("wr1_awid", awid, 0);
    chk("wr1_awcache", awcache, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      wdat_valid = 1; wdat_data = 64'hA0 + 64'(i); #1;
      chk("wr1_wdat_ready", wdat_ready, 1);
      tick();
      chk("wr1_wvalid", wvalid, 1);
      chk("wr1_wdata", wdata, 64'hA0 + 64'(i));
      chk("wr1_wlast", wlast, (i == 3) ? 1 : 0);
    end
    wdat_valid = 0; #1;
    chk("wr1_wdat_ready_empty", wdat_ready, 0);
    tick();
    chk("wr1_wvalid_drop", wvalid, 0);
    chk("wr1_aw_stable_valid", awvalid, 1);
    chk("wr1_aw_stable_addr", awaddr, 32'h100);
    chk("wr1_aw_stable_len", awlen, 3);
    awready = 1; tick(); awready = 0;
    chk("wr1_aw_done", awvalid, 0);
    bvalid = 1; bresp = 2'b00; #1;
    chk("wr1_bready", bready, 1);
    tick(); bvalid = 0;
    chk("wr1_resp_valid", resp_valid, 1);
    chk("wr1_resp_write", resp_write, 1);
    chk("wr1_resp_code", resp_code, 0);
    chk("wr1_resp_reject", resp_reject, 0);
    resp_ready = 1; tick();
    chk("wr1_resp_clear", resp_valid, 0);

    // Read WRAP 0x38 len 3 size 3
    set_req(0, 32'h38, 8'd3, 3'd3, 2'd2);
    chk("rd1_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("rd1_arvalid", arvalid, 1);
    chk("rd1_arburst", arburst, 2);
    chk("rd1_araddr", araddr, 32'h38);
    chk("rd1_arid", arid, 0);
    arready = 1; tick(); arready = 0;
    chk("rd1_ar_done", arvalid, 0);
    rvalid = 1; rlast = 1; rdata = 64'hDEADBEEF01234567; #1;
    chk("rd1_rdat_valid", rdat_valid, 1);
    chk("rd1_rdat_data", rdat_data, 64'hDEADBEEF01234567);
    chk("rd1_rready", rready, 1);
    tick(); rvalid = 0; rlast = 0;

    // WRAP len 2 is illegal
    set_req(0, 32'h38, 8'd2, 3'd3, 2'd2);
    chk("rej_wrap_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("rej_wrap_valid", resp_valid, 1);
    chk("rej_wrap_reject", resp_reject, 1);
    chk("rej_wrap_code", resp_code, 2'b10);
    chk("rej_wrap_write", resp_write, 0);
    chk("rej_wrap_no_ar", arvalid, 0);
    tick();

    // 4KB crossing: 0xFF8 + 16 bytes crosses, 0xFF0 + 16 ends exactly at the boundary
    set_req(1, 32'hFF8, 8'd3, 3'd2, 2'd1);
    tick(); req_valid = 0;
    chk("rej_4k_reject", resp_reject, 1);
    chk("rej_4k_write", resp_write, 1);
    chk("rej_4k_no_aw", awvalid, 0);
    tick();
    set_req(1, 32'hFF0, 8'd3, 3'd2, 2'd1);
    chk("ok_4k_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("ok_4k_awvalid", awvalid, 1);
    chk("ok_4k_awaddr", awaddr, 32'hFF0);
    chk("ok_4k_awid", awid, 1);
    awready = 1; tick();
    send_wbeats(4); tick();
    bvalid = 1; tick(); bvalid = 0; tick();

    // Outstanding limit of two writes
    set_req(1, 32'h200, 8'd0, 3'd2, 2'd1);
    tick(); req_valid = 0;
    chk("lim_a_awid", awid, 2);
    tick();
    set_req(1, 32'h240, 8'd0, 3'd2, 2'd1);
    tick(); req_valid = 0;
    chk("lim_b_awid", awid, 3);
    tick();
    set_req(1, 32'h300, 8'd0, 3'd2, 2'd1);
    chk("lim_c_stall", req_ready, 0);
    send_wbeats(2); #1;
    chk("lim_c_stall_after_w", req_ready, 0);
    bvalid = 1; tick(); bvalid = 0; #1;
    chk("lim_c_ready_after_b", req_ready, 1);
    tick(); req_valid = 0;
    chk("lim_c_awid", awid, 4);
    tick(); awready = 0;

    // Reset in the middle of a read burst
    set_req(0, 32'h400, 8'd3, 3'd2, 2'd1);
    tick(); req_valid = 0;
    chk("mid_arvalid", arvalid, 1);
    rvalid = 1; tick();
    rst = 1; tick();
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_rdat_valid", rdat_valid, 0);
    rst = 0; rvalid = 0; tick();
    set_req(0, 32'h500, 8'd0, 3'd2, 2'd1);
    chk("post_rst_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("post_rst_arvalid", arvalid, 1);
    chk("post_rst_arid", arid, 0);
    chk("post_rst_araddr", araddr, 32'h500);
    set_req(1, 32'h600, 8'd0, 3'd2, 2'd1);
    chk("post_rst_wr_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("post_rst_awid", awid, 0);
    chk("post_rst_wdat_ready", wdat_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
